usb_tx: RTL and testbench
=========================

# usb_tx

FT2232H asynchronous-FIFO (245 mode) transmit engine: the host-to-chip write side of the USB FIFO link. Internal logic pushes bytes over a valid/ready handshake into a small on-chip buffer. The block then drains them onto the FT2232H data bus with a WR# strobe, pacing every write on the chip's TXE# flag. All FT2232H timing is met with programmable cycle counts, given a 50 MHz clock.

## Interface

- `DEPTH`, 16, buffer depth in bytes; power of two, ≥ 2
- `SETUP_CYCLES`, 1, cycles `tx_data` is driven before WR# falls; ≥ 1
- `PULSE_CYCLES`, 2, WR# low width in cycles; ≥ 1
- `HOLD_CYCLES`, 1, cycles `tx_data` is held after WR# rises; ≥ 1
- `RECOVERY_CYCLES`, 3, bus-released wait before TXE# is sampled again; ≥ 2 to cover synchronizer latency
- `clock` in 1 system clock; all logic on the rising edge
- `reset` in 1 asynchronous, active-high reset
- `in_data` in 8 byte to transmit
- `in_valid` in 1 `in_data` is valid
- `in_ready` out 1 buffer can accept a byte; a byte is accepted on an edge where `in_valid && in_ready`
- `txe` in 1 FT2232H TXE#, active low, asynchronous to `clock`
- `wr` out 1 FT2232H WR#, active low
- `tx_data` out 8 data to the FT2232H bus
- `tx_oe` out 1 drive enable for the bidirectional bus pad; 1 = drive `tx_data`
- `count` out log2(DEPTH)+1 bytes currently buffered
- `busy` out 1 1 when the state machine is not IDLE

## Operation

- **Reset values.** While `reset` is high, and immediately on its assertion:
  - `wr`=1, `tx_oe`=0, `tx_data`=0x00, `count`=0, `busy`=0, `in_ready`=0.
  - FSM is IDLE; FIFO pointers are 0.
  - Both `txe` synchronizer flops are 1 (inactive).
  - `in_ready` goes to 1 on the first cycle after deassertion.
- **TXE# synchronizer.** `txe` passes through two flops; `txe_s` is the second flop. Only `txe_s` is used.
- **Buffer.** Circular FIFO of `DEPTH` bytes.
  - `in_ready` = !full, computed from `count` before any same-cycle pop. A full buffer refuses input even on a pop cycle.
  - Push and pop on the same edge: `count` is unchanged, both pointers advance.
  - Pointers wrap modulo `DEPTH`.
- **FSM states:**
  - IDLE: `tx_oe`=0, `wr`=1. If `count`≠0 and `txe_s`=0, pop the head byte into `tx_data`, set `tx_oe`=1, go to SETUP.
  - SETUP: `wr`=1, data driven. After `SETUP_CYCLES` cycles, go to STROBE.
  - STROBE: `wr`=0. After `PULSE_CYCLES` cycles, go to HOLD.
  - HOLD: `wr`=1, data still driven. After `HOLD_CYCLES` cycles, clear `tx_oe` and go to RECOVER.
  - RECOVER: bus released. After `RECOVERY_CYCLES` cycles, go to IDLE.
- **State timer.** A single down-counter sized for the largest parameter. It is loaded on every state entry.
- **TXE# during a transfer.** `txe_s` is ignored outside IDLE. TXE# rising mid-transfer does not abort the write.
- **Data stability.** `tx_data` changes only on the IDLE→SETUP edge. Between writes it keeps the last byte, undriven.
- **Reset mid-transfer.** `wr` returns to 1 and `tx_oe` to 0 asynchronously. Buffered bytes are discarded; no partial strobe is completed.

## Timing

- **Latency.** Byte accepted on edge E into an empty buffer, with `txe_s`=0 and FSM in IDLE:
  - `tx_oe`=1 and `tx_data` valid from edge E+1.
  - `wr` falls at edge E+1+S.
  - `wr` rises at E+1+S+P.
  - `tx_oe` falls at E+1+S+P+H.
  - FSM is back in IDLE at E+1+S+P+H+R.
  - Here S, P, H, R are `SETUP_CYCLES`, `PULSE_CYCLES`, `HOLD_CYCLES`, `RECOVERY_CYCLES`.
- **Throughput.** Sustained byte period is 1+S+P+H+R cycles, which is 8 cycles at defaults (160 ns at 50 MHz).
- **TXE# response.** A `txe` falling edge is visible to IDLE 2 cycles later.
- **`wr` glitch-free requirement.** `wr` is registered directly from state, not decoded combinationally.

## Test plan

- **Reset:** assert `reset` mid-STROBE with 4 bytes buffered → `wr`=1 and `tx_oe`=0 the same cycle; after release, `count`=0, `in_ready`=1, `busy`=0, and no further strobes occur.
- **Single byte, `txe` held 0, defaults:** push 0xA5 at edge E → `tx_data`=0xA5 and `tx_oe`=1 from E+1; `wr` low exactly for edges E+2..E+4 (2 cycles); `tx_oe` falls at E+5; `busy` drops at E+8.
- **Burst:** push 0x00..0x0F back-to-back with `txe`=0 → 16 `wr` pulses, 8 cycles apart, carrying 0x00..0x0F in order; `in_ready` stays 1 throughout.
- **Backpressure:** `txe`=1, push 17 bytes → `count`=16, `in_ready`=0 and the 17th byte is held; drop `txe` → first `wr` low 2+1+1 cycles later; `in_ready` returns after the first pop.
- **Flow control:** raise `txe` during STROBE of byte 1 with 3 bytes queued → byte 1 completes normally; no new SETUP while `txe_s`=1; lower `txe` → bytes 2 and 3 follow.
- **Pointer wrap:** push and drain 40 bytes with random `in_valid` gaps at `DEPTH`=4 → output sequence equals input sequence and `count` never exceeds 4.

Source files
------------

// File: rtl/usb_tx.sv
// FT2232H 245-mode transmit engine: byte FIFO drained onto the chip bus
// with a WR# strobe, paced by a synchronized TXE# flag.
`timescale 1ns/1ps
module usb_tx #(
  parameter int DEPTH           = 16,
  parameter int SETUP_CYCLES    = 1,
  parameter int PULSE_CYCLES    = 2,
  parameter int HOLD_CYCLES     = 1,
  parameter int RECOVERY_CYCLES = 3
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     txe,
  output logic                     wr,
  output logic [7:0]               tx_data,
  output logic                     tx_oe,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     busy
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int M1  = (SETUP_CYCLES > PULSE_CYCLES) ?
                       SETUP_CYCLES : PULSE_CYCLES;
  localparam int M2  = (HOLD_CYCLES > RECOVERY_CYCLES) ?
                       HOLD_CYCLES : RECOVERY_CYCLES;
  localparam int MX  = (M1 > M2) ? M1 : M2;
  localparam int TW  = (MX > 1) ? $clog2(MX) : 1;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SETUP   = 3'd1;
  localparam logic [2:0] STROBE  = 3'd2;
  localparam logic [2:0] HOLD    = 3'd3;
  localparam logic [2:0] RECOVER = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          wr_q, wr_d;
  logic          tx_oe_q, tx_oe_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          txe_m_q, txe_s_q;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          in_ready_q, in_ready_d;
  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic          push, pop;

  assign in_ready = in_ready_q;
  assign wr       = wr_q;
  assign tx_oe    = tx_oe_q;
  assign tx_data  = tx_data_q;
  assign count    = count_q;
  assign busy     = (state_q != IDLE);

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    wr_d      = wr_q;
    tx_oe_d   = tx_oe_q;
    tx_data_d = tx_data_q;
    pop       = 1'b0;
    push      = in_valid && in_ready_q;
    unique case (state_q)
      IDLE: begin
        wr_d    = 1'b1;
        tx_oe_d = 1'b0;
        if (count_q != '0 && !txe_s_q) begin
          pop       = 1'b1;
          tx_data_d = mem_q[rptr_q];
          tx_oe_d   = 1'b1;
          state_d   = SETUP;
          timer_d   = TW'(SETUP_CYCLES - 1);
        end
      end
      SETUP: begin
        if (timer_q == '0) begin
          state_d = STROBE;
          wr_d    = 1'b0;
          timer_d = TW'(PULSE_CYCLES - 1);
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      STROBE: begin
        if (timer_q == '0) begin
          state_d = HOLD;
          wr_d    = 1'b1;
          timer_d = TW'(HOLD_CYCLES - 1);
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      HOLD: begin
        if (timer_q == '0) begin
          state_d = RECOVER;
          tx_oe_d = 1'b0;
          timer_d = TW'(RECOVERY_CYCLES - 1);
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      RECOVER: begin
        if (timer_q == '0) begin
          state_d = IDLE;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        wr_d    = 1'b1;
        tx_oe_d = 1'b0;
      end
    endcase

    wptr_d = push ? wptr_q + AW'(1) : wptr_q;
    rptr_d = pop  ? rptr_q + AW'(1) : rptr_q;
    mem_d  = mem_q;
    if (push) mem_d[wptr_q] = in_data;

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // registered full flag keeps in_ready low through reset
    in_ready_d = (count_d != CW'(DEPTH));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      wr_q       <= 1'b1;
      tx_oe_q    <= 1'b0;
      tx_data_q  <= 8'h00;
      txe_m_q    <= 1'b1;
      txe_s_q    <= 1'b1;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      wr_q       <= wr_d;
      tx_oe_q    <= tx_oe_d;
      tx_data_q  <= tx_data_d;
      txe_m_q    <= txe;
      txe_s_q    <= txe_m_q;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
    end
  end

  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_usb_tx.sv
// Scoreboard bench for usb_tx: default build plus a DEPTH=4 build
// for pointer wrap.
`timescale 1ns/1ps
module tb_usb_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] in_data0, in_data1;
  logic       in_valid0, in_valid1;
  logic       in_ready0, in_ready1;
  logic       txe0, txe1;
  logic       wr0, wr1;
  logic [7:0] tx_data0, tx_data1;
  logic       tx_oe0, tx_oe1;
  logic [4:0] count0;
  logic [2:0] count1;
  logic       busy0, busy1;

  usb_tx u0 (
    .clock(clk), .reset(rst),
    .in_data(in_data0), .in_valid(in_valid0), .in_ready(in_ready0),
    .txe(txe0), .wr(wr0), .tx_data(tx_data0), .tx_oe(tx_oe0),
    .count(count0), .busy(busy0)
  );

  usb_tx #(.DEPTH(4)) u1 (
    .clock(clk), .reset(rst),
    .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
    .txe(txe1), .wr(wr1), .tx_data(tx_data1), .tx_oe(tx_oe1),
    .count(count1), .busy(busy1)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  logic [7:0] sb0[$];
  logic [7:0] sb1[$];
  int         falls0[$];
  int         falls1   = 0;
  logic       wr0_prev = 1'b1;
  logic       wr1_prev = 1'b1;
  logic       wrap_on  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && wr0_prev && !wr0) begin
      check("sb0_nonempty", sb0.size() != 0, 1);
      if (sb0.size() != 0) check("tx0_data", tx_data0, sb0.pop_front());
      check("tx0_oe_strobe", tx_oe0, 1);
      falls0.push_back(cyc);
    end
    if (!rst && wr1_prev && !wr1) begin
      check("sb1_nonempty", sb1.size() != 0, 1);
      if (sb1.size() != 0) check("tx1_data", tx_data1, sb1.pop_front());
      falls1++;
    end
    if (wrap_on) check("wrap_cnt_max", count1 <= 3'd4, 1);
    wr0_prev = wr0;
    wr1_prev = wr1;
  end

  task automatic push(input int which, input logic [7:0] d);
    int k = 0;
    if (which == 0) begin
      in_data0 = d; in_valid0 = 1'b1;
    end else begin
      in_data1 = d; in_valid1 = 1'b1;
    end
    while (((which == 0) ? !in_ready0 : !in_ready1) && k < 500) begin
      @(posedge clk); #1; k++;
    end
    if (k >= 500) check("push_timeout", k, 0);
    @(posedge clk); #1;
    if (which == 0) begin
      sb0.push_back(d); in_valid0 = 1'b0;
    end else begin
      sb1.push_back(d); in_valid1 = 1'b0;
    end
  endtask

  task automatic wait_idle(input int which);
    int k = 0;
    while (k < 2000 && ((which == 0) ? (count0 != 0 || busy0)
                                      : (count1 != 0 || busy1))) begin
      @(posedge clk); #1; k++;
    end
    if (k >= 2000) check("idle_timeout", k, 0);
  endtask

  task automatic wait_wr0_low();
    int k = 0;
    while (wr0 && k < 200) begin
      @(posedge clk); #1; k++;
    end
    if (k >= 200) check("wr0_low_timeout", k, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    in_data0 = 8'h00; in_data1 = 8'h00;
    in_valid0 = 1'b0; in_valid1 = 1'b0;
    txe0 = 1'b1; txe1 = 1'b0;
    #1;
    check("rst_wr", wr0, 1);
    check("rst_oe", tx_oe0, 0);
    check("rst_data", tx_data0, 8'h00);
    check("rst_count", count0, 0);
    check("rst_busy", busy0, 0);
    check("rst_ready", in_ready0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_ready", in_ready0, 1);
    check("post_rst_busy", busy0, 0);

    txe0 = 1'b0;
    repeat (3) @(posedge clk); #1;

    // single byte: now at E+1ns
    push(0, 8'hA5);
    check("e0_count", count0, 1);
    check("e0_oe", tx_oe0, 0);
    @(posedge clk); #1;
    check("e1_oe", tx_oe0, 1);
    check("e1_data", tx_data0, 8'hA5);
    check("e1_wr", wr0, 1);
    @(posedge clk); #1;
    check("e2_wr", wr0, 0);
    @(posedge clk); #1;
    check("e3_wr", wr0, 0);
    @(posedge clk); #1;
    check("e4_wr", wr0, 1);
    check("e4_oe", tx_oe0, 1);
    @(posedge clk); #1;
    check("e5_oe", tx_oe0, 0);
    check("e5_data_kept", tx_data0, 8'hA5);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("e7_busy", busy0, 1);
    @(posedge clk); #1;
    check("e8_busy", busy0, 0);

    // burst
    falls0.delete();
    for (int i = 0; i < 16; i++) begin
      check("burst_ready", in_ready0, 1);
      push(0, 8'(i));
    end
    wait_idle(0);
    check("burst_pulses", falls0.size(), 16);
    for (int i = 1; i < falls0.size(); i++)
      check("burst_gap", falls0[i] - falls0[i-1], 8);

    // backpressure
    txe0 = 1'b1;
    repeat (3) @(posedge clk); #1;
    for (int i = 0; i < 16; i++) push(0, 8'h40 + 8'(i));
    in_data0 = 8'h77; in_valid0 = 1'b1;
    repeat (2) @(posedge clk); #1;
    check("bp_count_full", count0, 16);
    check("bp_ready_low", in_ready0, 0);
    check("bp_no_wr", wr0, 1);
    check("bp_idle", busy0, 0);
    txe0 = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("bp_ready_back", in_ready0, 1);
    check("bp_count_pop", count0, 15);
    check("bp_wr_not_yet", wr0, 1);
    @(posedge clk); #1;
    check("bp_wr_low", wr0, 0);
    check("bp_count_17th", count0, 16);
    sb0.push_back(8'h77);
    in_valid0 = 1'b0;
    wait_idle(0);

    // flow control
    falls0.delete();
    push(0, 8'hB1);
    push(0, 8'hB2);
    push(0, 8'hB3);
    wait_wr0_low();
    txe0 = 1'b1;
    repeat (20) @(posedge clk); #1;
    check("fc_one_pulse", falls0.size(), 1);
    check("fc_count", count0, 2);
    check("fc_idle", busy0, 0);
    txe0 = 1'b0;
    wait_idle(0);
    check("fc_three_pulses", falls0.size(), 3);

    // reset mid-strobe with 4 bytes buffered
    for (int i = 0; i < 6; i++) push(0, 8'hC0 + 8'(i));
    wait_wr0_low();
    check("mr_buffered", count0, 4);
    #2;
    rst = 1'b1;
    #1;
    check("mr_wr", wr0, 1);
    check("mr_oe", tx_oe0, 0);
    check("mr_count", count0, 0);
    check("mr_ready", in_ready0, 0);
    sb0.delete();
    falls0.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("mr_post_count", count0, 0);
    check("mr_post_ready", in_ready0, 1);
    check("mr_post_busy", busy0, 0);
    repeat (30) @(posedge clk); #1;
    check("mr_no_strobe", falls0.size(), 0);
    check("mr_oe_off", tx_oe0, 0);

    // pointer wrap at DEPTH=4
    wrap_on = 1'b1;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
      push(1, 8'($urandom));
    end
    wait_idle(1);
    wrap_on = 1'b0;
    check("wrap_pulses", falls1, 40);
    check("wrap_sb1_empty", sb1.size(), 0);
    check("final_sb0_empty", sb0.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
